set_cmd_scheduler: RTL and testbench

- Upstream command stage for the SET candidate-counting engine.
- Accepts circle-query commands from the host via a valid/ready push interface and buffers them in a small FIFO.
- Issues one command at a time over the engine's en/busy handshake, captures the single-cycle candidate/valid result, and presents it tagged on a valid/ready result port.
- Adds input checking, a watchdog and a completion counter so the host never has to track engine timing.

---
 rtl/set_cmd_scheduler.sv | 164 ++++++++++++++++
 tb/tb_set_cmd_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_cmd_scheduler.sv
// Buffers host circle-query commands, runs them one at a time on the SET engine and returns tagged results.
// Illegal modes are answered with an error without starting the engine; a watchdog turns a silent engine into an error result.
module set_cmd_scheduler #(
  parameter int CMD_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [23:0]      cmd_central,
  input  logic [11:0]      cmd_radius,
  input  logic [1:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_candidate,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_mode,
  output logic             res_err,
  output logic [15:0]      done_cnt
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT} state_t;

  logic [23:0]      cen_mem [CMD_DEPTH];
  logic [11:0]      rad_mem [CMD_DEPTH];
  logic [1:0]       mode_mem[CMD_DEPTH];
  logic [TAG_W-1:0] tag_mem [CMD_DEPTH];

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  state_t           state_q;
  logic [WW-1:0]    wd_q;
  logic [TAG_W-1:0] fl_tag_q, head_tag;
  logic [1:0]       fl_mode_q;
  logic             res_valid_q, res_err_q;
  logic [7:0]       res_cand_q;
  logic [TAG_W-1:0] res_tag_q;
  logic [1:0]       res_mode_q;
  logic [15:0]      done_q;
  logic             push, pop, illegal_pop;

  assign cmd_ready   = (cnt_q != (AW+1)'(CMD_DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign set_central = cen_mem[rd_ptr_q];
  assign set_radius  = rad_mem[rd_ptr_q];
  assign set_mode    = mode_mem[rd_ptr_q];
  assign head_tag    = tag_mem[rd_ptr_q];
  assign set_en      = (state_q == ISSUE) && !set_busy;
  assign illegal_pop = (state_q == CHECK) && (set_mode == 2'd3);
  assign pop         = illegal_pop || set_en;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cen_mem[wr_ptr_q]  <= cmd_central;
      rad_mem[wr_ptr_q]  <= cmd_radius;
      mode_mem[wr_ptr_q] <= cmd_mode;
      tag_mem[wr_ptr_q]  <= cmd_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      fl_tag_q    <= '0;
      fl_mode_q   <= '0;
      res_valid_q <= 1'b0;
      res_cand_q  <= '0;
      res_tag_q   <= '0;
      res_mode_q  <= '0;
      res_err_q   <= 1'b0;
      done_q      <= '0;
    end else begin
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
        if (done_q != 16'hFFFF) done_q <= done_q + 16'd1;
      end
      case (state_q)
        IDLE: if (cnt_q != '0 && !res_valid_q) state_q <= CHECK;
        CHECK: begin
          if (set_mode == 2'd3) begin
            res_valid_q <= 1'b1;
            res_cand_q  <= '0;
            res_err_q   <= 1'b1;
            res_tag_q   <= head_tag;
            res_mode_q  <= set_mode;
            state_q     <= IDLE;
          end else begin
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (set_en) begin
            fl_tag_q  <= head_tag;
            fl_mode_q <= set_mode;
            wd_q      <= '0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          // A result arriving on the expiry cycle still counts as a success.
          if (set_valid) begin
            res_valid_q <= 1'b1;
            res_cand_q  <= set_candidate;
            res_err_q   <= 1'b0;
            res_tag_q   <= fl_tag_q;
            res_mode_q  <= fl_mode_q;
            state_q     <= IDLE;
          end else if (wd_q == WW'(TIMEOUT_CYC - 2)) begin
            res_valid_q <= 1'b1;
            res_cand_q  <= '0;
            res_err_q   <= 1'b1;
            res_tag_q   <= fl_tag_q;
            res_mode_q  <= fl_mode_q;
            state_q     <= IDLE;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid     = res_valid_q;
  assign res_candidate = res_cand_q;
  assign res_tag       = res_tag_q;
  assign res_mode      = res_mode_q;
  assign res_err       = res_err_q;
  assign done_cnt      = done_q;
endmodule

// File: tb/tb_set_cmd_scheduler.sv
// Scoreboarded bench for set_cmd_scheduler with a behavioural SET engine stand-in.
module tb_set_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [23:0] cmd_central = '0;
  logic [11:0] cmd_radius = '0;
  logic [1:0]  cmd_mode = '0;
  logic [3:0]  cmd_tag = '0;
  logic        set_en, set_busy, set_valid;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic [7:0]  set_candidate;
  logic        res_valid, res_ready = 1'b0, res_err;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic [1:0]  res_mode;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  set_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_central(cmd_central),
    .cmd_radius(cmd_radius), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_mode(res_mode), .res_err(res_err), .done_cnt(done_cnt)
  );

  typedef struct packed {
    logic [7:0] cand;
    logic [3:0] tag;
    logic [1:0] mode;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0, fails = 0, cyc = 0, en_cnt = 0, model_done = 0, last_acc = 0;
  int   eng_lat = 10;
  bit   eng_hang = 0, rnd_rdy = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Points of a 16x16 lattice inside circle A and/or circle B.
  function automatic logic [7:0] ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int xa = c[23:20], ya = c[19:16], xb = c[15:12], yb = c[11:8];
    int ra = r[11:8], rb = r[7:4], n = 0;
    bit ina, inb;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        ina = ((x-xa)*(x-xa) + (y-ya)*(y-ya)) <= ra*ra;
        inb = ((x-xb)*(x-xb) + (y-yb)*(y-yb)) <= rb*rb;
        case (m)
          2'd0: n += int'(ina);
          2'd1: n += int'(ina && inb);
          2'd2: n += int'(ina ^ inb);
          default: n += 0;
        endcase
      end
    return 8'(n);
  endfunction

  function automatic exp_t mk(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] t);
    exp_t e;
    e.cand = (m == 2'd3) ? 8'd0 : ref_count(c, r, m);
    e.tag  = t;
    e.mode = m;
    e.err  = (m == 2'd3);
    return e;
  endfunction

  // Engine stand-in: busy for one cycle after reset, then accepts set_en and answers after eng_lat cycles.
  int   e_cnt;
  bit   e_post;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      set_busy <= 1'b1; e_post <= 1'b1; set_valid <= 1'b0; set_candidate <= '0; e_cnt <= 0;
    end else begin
      set_valid <= 1'b0;
      if (e_post) begin
        e_post <= 1'b0; set_busy <= 1'b0;
      end else if (!set_busy && set_en) begin
        set_busy <= 1'b1; e_cnt <= eng_lat;
        set_candidate <= ref_count(set_central, set_radius, set_mode);
      end else if (set_busy) begin
        if (e_cnt <= 1) begin
          set_busy <= 1'b0; set_valid <= !eng_hang;
        end else e_cnt <= e_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (rnd_rdy) begin #1; res_ready = ($urandom_range(0, 2) != 0); end

  // Monitor: pops the scoreboard on every result handshake and watches held results.
  bit   prev_hold = 0;
  exp_t prev_res, e_pop;
  always @(negedge clk) begin
    if (rst) prev_hold = 0;
    else begin
      if (set_en) en_cnt++;
      if (prev_hold) begin
        chk("res_hold_valid", int'(res_valid), 1);
        if (res_valid) chk("res_hold_stable", int'({res_candidate, res_tag, res_mode, res_err}), int'(prev_res));
      end
      if (res_valid && res_ready) begin
        chk("done_cnt", int'(done_cnt), model_done);
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got tag %0d with nothing expected", res_tag);
        end else begin
          e_pop = sb_q.pop_front();
          chk("res_candidate", int'(res_candidate), int'(e_pop.cand));
          chk("res_tag", int'(res_tag), int'(e_pop.tag));
          chk("res_mode", int'(res_mode), int'(e_pop.mode));
          chk("res_err", int'(res_err), int'(e_pop.err));
        end
        if (model_done < 65535) model_done++;
      end
      prev_hold = res_valid && !res_ready;
      prev_res  = {res_candidate, res_tag, res_mode, res_err};
    end
  end

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] t, input exp_t e);
    int  n = 0;
    bit  acc = 0;
    cmd_valid = 1'b1; cmd_central = c; cmd_radius = r; cmd_mode = m; cmd_tag = t;
    while (!acc && n < 3000) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b0;
    if (acc) begin sb_q.push_back(e); last_acc = cyc; end
    else chk("push_accept", 0, 1);
  endtask

  task automatic push_rand(input logic [3:0] t, input bit legal);
    logic [23:0] c = {$urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)} << 8;
    logic [11:0] r = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'd0};
    logic [1:0]  m = legal ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    push(c, r, m, t, mk(c, r, m, t));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk("drain_pending", sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_res_valid"}, int'(res_valid), 0);
    chk({pfx, "_res_candidate"}, int'(res_candidate), 0);
    chk({pfx, "_res_tag"}, int'(res_tag), 0);
    chk({pfx, "_res_mode"}, int'(res_mode), 0);
    chk({pfx, "_res_err"}, int'(res_err), 0);
    chk({pfx, "_done_cnt"}, int'(done_cnt), 0);
    chk({pfx, "_set_en"}, int'(set_en), 0);
    chk({pfx, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, c0, n;
    repeat (3) @(posedge clk);
    @(negedge clk) chk_reset_outputs("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Single count-A query.
    res_ready = 1'b1; eng_lat = 20; e0 = en_cnt;
    push(24'h440000, 12'h200, 2'd0, 4'd1, '{8'd13, 4'd1, 2'd0, 1'b0});
    drain(500);
    chk("t1_set_en_pulses", en_cnt - e0, 1);
    chk("t1_done_cnt", int'(done_cnt), 1);

    // Intersection then xor on the same geometry.
    push(24'h446400, 12'h220, 2'd1, 4'd2, '{8'd5, 4'd2, 2'd1, 1'b0});
    push(24'h446400, 12'h220, 2'd2, 4'd3, '{8'd16, 4'd3, 2'd2, 1'b0});
    drain(1000);

    // Fill the FIFO while a held result blocks issue.
    res_ready = 1'b0;
    push(24'h000000, 12'h000, 2'd3, 4'd5, '{8'd0, 4'd5, 2'd3, 1'b1});
    repeat (4) @(posedge clk);
    #1 e0 = en_cnt;
    for (int i = 0; i < 4; i++) push_rand(4'(8 + i), 1);
    cmd_valid = 1'b1;
    @(negedge clk) chk("full_cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1 res_ready = 1'b1;
    push_rand(4'd12, 1);
    drain(2000);
    chk("fill_set_en_pulses", en_cnt - e0, 5);

    // Illegal mode answers quickly without the engine, then a legal one still runs.
    e0 = en_cnt;
    push(24'h123400, 12'h110, 2'd3, 4'd7, '{8'd0, 4'd7, 2'd3, 1'b1});
    c0 = last_acc; n = 0;
    while (!res_valid && n < 10) begin @(negedge clk); n++; end
    chk("illegal_latency_ok", int'((cyc - c0) <= 3), 1);
    drain(100);
    chk("illegal_no_set_en", en_cnt - e0, 0);
    push_rand(4'd4, 1);
    drain(500);
    chk("after_illegal_set_en", en_cnt - e0, 1);

    // Silent engine: watchdog error, held result blocks the next issue.
    res_ready = 1'b0; eng_hang = 1; eng_lat = 5;
    push(24'h440000, 12'h200, 2'd0, 4'd9, '{8'd0, 4'd9, 2'd0, 1'b1});
    push(24'h446400, 12'h220, 2'd1, 4'd10, '{8'd5, 4'd10, 2'd1, 1'b0});
    n = 0;
    while (!set_en && n < 100) begin @(negedge clk); n++; end
    c0 = cyc; n = 0;
    while (!res_valid && n < 800) begin @(negedge clk); n++; end
    chk("timeout_latency", cyc - c0, 512);
    chk("timeout_err", int'(res_err), 1);
    chk("timeout_candidate", int'(res_candidate), 0);
    e0 = en_cnt;
    repeat (100) @(negedge clk);
    chk("held_no_set_en", en_cnt - e0, 0);
    @(posedge clk); #1 eng_hang = 0; res_ready = 1'b1;
    drain(1000);
    chk("after_timeout_set_en", en_cnt - e0, 1);

    // Randomized traffic with random backpressure and engine latency.
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      eng_lat = $urandom_range(2, 30);
      push_rand(4'($urandom_range(0, 15)), 0);
    end
    drain(20000);
    rnd_rdy = 0;
    @(posedge clk); #1 res_ready = 1'b1;

    // Reset mid-WAIT with commands queued.
    eng_lat = 200;
    for (int i = 0; i < 3; i++) push_rand(4'(i), 1);
    n = 0;
    while (!set_en && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(posedge clk);
    #1 rst = 1'b1; sb_q.delete(); model_done = 0;
    @(negedge clk) chk_reset_outputs("midrst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk) chk_reset_outputs("postrst");
    e0 = en_cnt;
    repeat (300) @(negedge clk);
    chk("postrst_no_set_en", en_cnt - e0, 0);
    chk("postrst_no_result", int'(res_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
